// File: rtl/clock_pkg.sv
// Shared constants, mode encoding and field helper for the time-of-day core.
package clock_pkg;

  localparam int TIME_W = 6;

  localparam logic [TIME_W-1:0] SEC_MAX  = 6'd59;
  localparam logic [TIME_W-1:0] MIN_MAX  = 6'd59;
  localparam logic [TIME_W-1:0] HOUR_MAX = 6'd23;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  // Increment a time field, returning to zero after its maximum value.
  function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] val,
                                                 input logic [TIME_W-1:0] max_val);
    return (val == max_val) ? '0 : val + 1'b1;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for one raw push button.
// The one-cycle pulse goes high on the third clock edge after the raw rise.
module btn_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  // Next-state for the synchronizer chain and the registered edge pulse.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = sync2_q & ~prev_q;
  end

  // Synchronizer and edge-detector registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/clock_timekeeper.sv
// Time-of-day core: 1 Hz prescaler, 24 h seconds/minutes/hours counters,
// two-button set-mode FSM and a free-running digit-scan phase counter.
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ   = 10000000,
  parameter int SCAN_DIV = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [11:0] data_show,
  output logic [2:0]  byte_status,
  output logic        second_tick,
  output logic [1:0]  set_active
);

  localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(CLK_HZ - 1);
  localparam logic [SCAN_W-1:0]  SCAN_TC  = SCAN_W'(SCAN_DIV - 1);

  logic mode_pulse;
  logic inc_pulse;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [SCAN_W-1:0]  scan_q, scan_d;
  logic [2:0]         byte_q, byte_d;
  logic [TIME_W-1:0]  sec_q, sec_d;
  logic [TIME_W-1:0]  min_q, min_d;
  logic [TIME_W-1:0]  hour_q, hour_d;
  mode_e              mode_q, mode_d;

  btn_sync_edge u_mode_sync (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (btn_mode),
    .pulse   (mode_pulse)
  );

  btn_sync_edge u_inc_sync (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (btn_inc),
    .pulse   (inc_pulse)
  );

  assign second_tick = (presc_q == PRESC_TC);

  // Free-running scan divider stepping the digit phase, independent of mode.
  always_comb begin
    scan_d = scan_q + 1'b1;
    byte_d = byte_q;
    if (scan_q == SCAN_TC) begin
      scan_d = '0;
      byte_d = byte_q + 3'd1;
    end
  end

  // Mode FSM, prescaler and time counters. A mode edge wins over an inc
  // edge in the same cycle; leaving SET_MIN restarts the second boundary.
  always_comb begin
    mode_d  = mode_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    presc_d = second_tick ? '0 : presc_q + 1'b1;

    if (mode_pulse) begin
      unique case (mode_q)
        MODE_RUN:      mode_d = MODE_SET_HOUR;
        MODE_SET_HOUR: mode_d = MODE_SET_MIN;
        MODE_SET_MIN: begin
          mode_d  = MODE_RUN;
          sec_d   = '0;
          presc_d = '0;
        end
        default:       mode_d = MODE_RUN;
      endcase
    end

    if ((mode_q == MODE_RUN) && second_tick) begin
      sec_d = wrap_inc(sec_q, SEC_MAX);
      if (sec_q == SEC_MAX) begin
        min_d = wrap_inc(min_q, MIN_MAX);
        if (min_q == MIN_MAX) begin
          hour_d = wrap_inc(hour_q, HOUR_MAX);
        end
      end
    end else if (inc_pulse && !mode_pulse) begin
      if (mode_q == MODE_SET_HOUR) begin
        hour_d = wrap_inc(hour_q, HOUR_MAX);
      end else if (mode_q == MODE_SET_MIN) begin
        min_d = wrap_inc(min_q, MIN_MAX);
      end
    end
  end

  // State registers; everything clears asynchronously on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      scan_q  <= '0;
      byte_q  <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      mode_q  <= MODE_RUN;
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      byte_q  <= byte_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      mode_q  <= mode_d;
    end
  end

  assign data_show   = {hour_q, min_q};
  assign set_active  = mode_q;
  assign byte_status = byte_q;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Self-checking bench for clock_timekeeper with a seconds-of-day reference model.
module tb_clock_timekeeper;

  localparam int CLK_HZ   = 4;
  localparam int SCAN_DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_mode;
  logic        btn_inc;
  logic [11:0] data_show;
  logic [2:0]  byte_status;
  logic        second_tick;
  logic [1:0]  set_active;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_mode, m_h, m_m, m_s, m_presc, m_scan, m_byte;
  bit hm[4];
  bit hi[4];

  always #5 clk = ~clk;

  clock_timekeeper #(.CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV)) dut (
    .clock       (clk),
    .reset       (rst_n),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .data_show   (data_show),
    .byte_status (byte_status),
    .second_tick (second_tick),
    .set_active  (set_active)
  );

  function automatic logic [17:0] exp_vec();
    logic tk;
    tk = (m_presc == CLK_HZ - 1);
    return {6'(m_h), 6'(m_m), 2'(m_mode), tk, 3'(m_byte)};
  endfunction

  function automatic logic [17:0] act_vec();
    return {data_show, set_active, second_tick, byte_status};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_presc = 0; m_scan = 0; m_byte = 0;
    for (int k = 0; k < 4; k++) begin hm[k] = 0; hi[k] = 0; end
  endtask

  // One clock edge of the model: a button counts when its raw level, as
  // sampled three edges earlier, had just risen.
  task automatic model_edge();
    bit mp, ip, tk;
    int old_mode, new_presc, tod;
    mp = hm[2] && !hm[3];
    ip = hi[2] && !hi[3];
    tk = (m_presc == CLK_HZ - 1);
    old_mode  = m_mode;
    new_presc = tk ? 0 : m_presc + 1;
    if (mp) begin
      if (old_mode == 2) begin m_s = 0; new_presc = 0; end
      m_mode = (old_mode + 1) % 3;
    end
    if (old_mode == 0 && tk) begin
      tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
      m_h = tod / 3600; m_m = (tod / 60) % 60; m_s = tod % 60;
    end else if (!mp && ip) begin
      if (old_mode == 1) m_h = (m_h + 1) % 24;
      if (old_mode == 2) m_m = (m_m + 1) % 60;
    end
    m_presc = new_presc;
    if (m_scan == SCAN_DIV - 1) m_byte = (m_byte + 1) % 8;
    m_scan = (m_scan + 1) % SCAN_DIV;
    for (int k = 3; k > 0; k--) begin hm[k] = hm[k-1]; hi[k] = hi[k-1]; end
    hm[0] = btn_mode;
    hi[0] = btn_inc;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m; btn_inc = i;
    cyc(); cyc();
    btn_mode = 1'b0; btn_inc = 1'b0;
    cyc(); cyc(); cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      n_tests++;
      if (act_vec() !== 18'd0) begin
        n_fail++; $display("FAIL reset_hold got %h exp %h", act_vec(), 18'd0);
      end
    end
    rst_n = 1'b1;
    cyc();
    n_tests++;
    if (act_vec() !== 18'd0) begin
      n_fail++; $display("FAIL reset_first_edge got %h exp %h", act_vec(), 18'd0);
    end
  endtask

  task automatic test_run();
    int ticks = 0, last = -1, c = 0;
    while (ticks < 60 && c < 400) begin
      cyc(); c++;
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL run_cycle got %h exp %h", act_vec(), exp_vec());
      end
      if (second_tick) begin
        if (last >= 0) begin
          n_tests++;
          if (c - last != CLK_HZ) begin
            n_fail++; $display("FAIL tick_period got %0d exp %0d", c - last, CLK_HZ);
          end
        end
        last = c; ticks++;
      end
    end
    n_tests++;
    if (ticks < 60) begin
      n_fail++; $display("FAIL run_timeout got %0d ticks exp 60", ticks);
    end
    cyc();
    n_tests++;
    if (data_show !== 12'h001) begin
      n_fail++; $display("FAIL run_60_ticks got %h exp %h", data_show, 12'h001);
    end
  endtask

  task automatic test_day_wrap();
    int n, ticks = 0, c = 0;
    press(1'b1, 1'b0);
    n = (23 - m_h + 24) % 24;
    repeat (n) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    n = (59 - m_m + 60) % 60;
    repeat (n) press(1'b0, 1'b1);
    n_tests++;
    if (data_show !== {6'd23, 6'd59}) begin
      n_fail++; $display("FAIL set_2359 got %h exp %h", data_show, {6'd23, 6'd59});
    end
    press(1'b1, 1'b0);
    while (ticks < 60 && c < 400) begin
      cyc(); c++;
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL wrap_cycle got %h exp %h", act_vec(), exp_vec());
      end
      if (second_tick) ticks++;
    end
    cyc();
    n_tests++;
    if (data_show !== 12'd0) begin
      n_fail++; $display("FAIL day_wrap got %h exp %h", data_show, 12'd0);
    end
  endtask

  task automatic test_set_wrap();
    int h0, mm0, n;
    press(1'b1, 1'b0);
    n_tests++;
    if (set_active !== 2'd1) begin
      n_fail++; $display("FAIL to_set_hour got %0d exp 1", set_active);
    end
    h0 = m_h;
    repeat (25) press(1'b0, 1'b1);
    n_tests++;
    if (data_show[11:6] !== 6'((h0 + 25) % 24)) begin
      n_fail++; $display("FAIL hour_wrap got %0d exp %0d", data_show[11:6], (h0 + 25) % 24);
    end
    press(1'b1, 1'b0);
    n_tests++;
    if (set_active !== 2'd2) begin
      n_fail++; $display("FAIL to_set_min got %0d exp 2", set_active);
    end
    mm0 = m_m;
    repeat (61) press(1'b0, 1'b1);
    n_tests++;
    if (data_show[5:0] !== 6'((mm0 + 61) % 60)) begin
      n_fail++; $display("FAIL min_wrap got %0d exp %0d", data_show[5:0], (mm0 + 61) % 60);
    end
    btn_mode = 1'b1;
    cyc(); cyc();
    btn_mode = 1'b0;
    cyc(); cyc();
    n_tests++;
    if (set_active !== 2'd0 || second_tick !== 1'b0) begin
      n_fail++; $display("FAIL exit_set got mode %0d tick %0d exp 0 0", set_active, second_tick);
    end
    n = 1;
    while (!second_tick && n < 12) begin cyc(); n++; end
    n_tests++;
    if (n != CLK_HZ) begin
      n_fail++; $display("FAIL first_tick_after_set got %0d exp %0d", n, CLK_HZ);
    end
  endtask

  task automatic test_simul_freeze();
    int h0, mm0, ticks = 0, c = 0;
    h0 = m_h;
    press(1'b1, 1'b1);
    n_tests++;
    if (set_active !== 2'd1 || data_show[11:6] !== 6'(h0)) begin
      n_fail++; $display("FAIL simul_edges got mode %0d hour %0d exp 1 %0d", set_active, data_show[11:6], h0);
    end
    mm0 = m_m;
    while (ticks < 10 && c < 100) begin
      cyc(); c++;
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL freeze_cycle got %h exp %h", act_vec(), exp_vec());
      end
      if (second_tick) ticks++;
    end
    n_tests++;
    if (data_show[5:0] !== 6'(mm0) || ticks < 10) begin
      n_fail++; $display("FAIL freeze got min %0d ticks %0d exp %0d 10", data_show[5:0], ticks, mm0);
    end
  endtask

  task automatic test_held_scan();
    int mm0, changes = 0;
    bit saw_wrap = 0;
    logic [2:0] prev;
    press(1'b1, 1'b0);
    n_tests++;
    if (set_active !== 2'd2) begin
      n_fail++; $display("FAIL held_to_set_min got %0d exp 2", set_active);
    end
    mm0 = m_m;
    prev = byte_status;
    btn_inc = 1'b1;
    repeat (50) begin
      cyc();
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL held_cycle got %h exp %h", act_vec(), exp_vec());
      end
      if (byte_status !== prev) changes++;
      if (prev == 3'd7 && byte_status == 3'd0) saw_wrap = 1;
      prev = byte_status;
    end
    btn_inc = 1'b0;
    repeat (4) cyc();
    n_tests++;
    if (data_show[5:0] !== 6'((mm0 + 1) % 60)) begin
      n_fail++; $display("FAIL held_inc got %0d exp %0d", data_show[5:0], (mm0 + 1) % 60);
    end
    n_tests++;
    if (changes != 50 / SCAN_DIV || !saw_wrap) begin
      n_fail++; $display("FAIL scan_steps got %0d wrap %0d exp %0d 1", changes, saw_wrap, 50 / SCAN_DIV);
    end
  endtask

  task automatic test_async_reset();
    int n;
    n = (30 - m_m + 60) % 60;
    repeat (n) press(1'b0, 1'b1);
    n_tests++;
    if (data_show[5:0] !== 6'd30 || set_active !== 2'd2) begin
      n_fail++; $display("FAIL pre_reset got min %0d mode %0d exp 30 2", data_show[5:0], set_active);
    end
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (act_vec() !== 18'd0) begin
      n_fail++; $display("FAIL async_reset got %h exp %h", act_vec(), 18'd0);
    end
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (20) begin
      cyc();
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL post_reset got %h exp %h", act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    repeat (1500) begin
      if ($urandom_range(0, 5) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 3) == 0) btn_inc = ~btn_inc;
      cyc();
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_cycle got %h exp %h", act_vec(), exp_vec());
      end
    end
    btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run();
    test_day_wrap();
    test_set_wrap();
    test_simul_freeze();
    test_held_scan();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
